// File: rtl/fft_peak_sequencer.sv
// Scans one buffered FFT frame bin by bin and reports the largest-magnitude bin in the search
// window [MIN_BIN, SCAN_BINS-1]. Bins past the window are drained so the frame is fully consumed.
module fft_peak_sequencer #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned FFT_SIZE   = 256,
  parameter int unsigned SCAN_BINS  = 128,
  parameter int unsigned MIN_BIN    = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        frame_ready_i,
  input  logic [2*DATA_WIDTH-1:0]     bin_data_i,
  input  logic                        bin_valid_i,
  output logic                        bin_ready_o,
  output logic [$clog2(FFT_SIZE)-1:0] peak_bin_o,
  output logic [2*DATA_WIDTH-1:0]     peak_mag_o,
  output logic                        peak_valid_o,
  input  logic                        peak_ready_i,
  output logic                        busy_o,
  output logic [15:0]                 frame_count_o,
  output logic                        overrun_o
);

  localparam int unsigned AW = $clog2(FFT_SIZE);
  localparam int unsigned MW = 2 * DATA_WIDTH;
  localparam bit SkipDrain = (SCAN_BINS >= FFT_SIZE);
  localparam logic [AW-1:0] MinIdx      = AW'(MIN_BIN);
  localparam logic [AW-1:0] LastIdx     = AW'(FFT_SIZE - 1);
  localparam logic [AW-1:0] ScanLastIdx = SkipDrain ? AW'(FFT_SIZE - 1) : AW'(SCAN_BINS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StReport} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   bin_idx_q, bin_idx_d;
  logic [MW-1:0]   run_mag_q, run_mag_d;
  logic [AW-1:0]   run_bin_q, run_bin_d;
  logic [MW-1:0]   peak_mag_q, peak_mag_d;
  logic [AW-1:0]   peak_bin_q, peak_bin_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            overrun_q, overrun_d;

  // Full-precision squares: each square is at most 2^(MW-2), so the sum cannot overflow MW bits.
  logic signed [MW-1:0] re_ext, im_ext, re_sq, im_sq;
  logic [MW-1:0]        mag;
  logic                 accept, in_range;

  assign re_ext = {{DATA_WIDTH{bin_data_i[DATA_WIDTH-1]}}, bin_data_i[DATA_WIDTH-1:0]};
  assign im_ext = {{DATA_WIDTH{bin_data_i[MW-1]}}, bin_data_i[MW-1:DATA_WIDTH]};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign mag    = $unsigned(re_sq) + $unsigned(im_sq);

  assign bin_ready_o   = (state_q == StScan) || (state_q == StDrain);
  assign peak_valid_o  = (state_q == StReport);
  assign busy_o        = (state_q != StIdle);
  assign peak_bin_o    = peak_bin_q;
  assign peak_mag_o    = peak_mag_q;
  assign frame_count_o = frame_cnt_q;
  assign overrun_o     = overrun_q;

  assign accept   = bin_valid_i && bin_ready_o;
  assign in_range = (bin_idx_q >= MinIdx) && (bin_idx_q <= ScanLastIdx);

  always_comb begin
    state_d     = state_q;
    bin_idx_d   = bin_idx_q;
    run_mag_d   = run_mag_q;
    run_bin_d   = run_bin_q;
    peak_mag_d  = peak_mag_q;
    peak_bin_d  = peak_bin_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;

    if (bin_valid_i && ((state_q == StIdle) || (state_q == StReport))) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_ready_i) begin
          state_d   = StScan;
          bin_idx_d = '0;
          run_mag_d = '0;
          run_bin_d = MinIdx;
        end
      end
      StScan: begin
        if (accept) begin
          bin_idx_d = bin_idx_q + AW'(1);
          // Strict compare so a tie keeps the lower bin.
          if (in_range && (mag > run_mag_q)) begin
            run_mag_d = mag;
            run_bin_d = bin_idx_q;
          end
          if (bin_idx_q == ScanLastIdx) begin
            if (SkipDrain) begin
              state_d    = StReport;
              peak_mag_d = run_mag_d;
              peak_bin_d = run_bin_d;
            end else begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        if (accept) begin
          bin_idx_d = bin_idx_q + AW'(1);
          if (bin_idx_q == LastIdx) begin
            state_d    = StReport;
            peak_mag_d = run_mag_q;
            peak_bin_d = run_bin_q;
          end
        end
      end
      StReport: begin
        if (peak_ready_i) begin
          state_d     = StIdle;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      bin_idx_q   <= '0;
      run_mag_q   <= '0;
      run_bin_q   <= '0;
      peak_mag_q  <= '0;
      peak_bin_q  <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_idx_q   <= bin_idx_d;
      run_mag_q   <= run_mag_d;
      run_bin_q   <= run_bin_d;
      peak_mag_q  <= peak_mag_d;
      peak_bin_q  <= peak_bin_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fft_peak_sequencer.sv
// Scoreboard bench for fft_peak_sequencer: each full frame pushes its expected peak, and the
// report handshake pops and compares it.
module tb_fft_peak_sequencer;

  localparam int DW = 18;
  localparam int N  = 256;
  localparam int SB = 128;
  localparam int MB = 1;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic            frame_ready_i = 1'b0;
  logic [2*DW-1:0] bin_data_i = '0;
  logic            bin_valid_i = 1'b0;
  logic            bin_ready_o;
  logic [7:0]      peak_bin_o;
  logic [2*DW-1:0] peak_mag_o;
  logic            peak_valid_o;
  logic            peak_ready_i = 1'b0;
  logic            busy_o;
  logic [15:0]     frame_count_o;
  logic            overrun_o;

  fft_peak_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .frame_ready_i (frame_ready_i),
    .bin_data_i    (bin_data_i),
    .bin_valid_i   (bin_valid_i),
    .bin_ready_o   (bin_ready_o),
    .peak_bin_o    (peak_bin_o),
    .peak_mag_o    (peak_mag_o),
    .peak_valid_o  (peak_valid_o),
    .peak_ready_i  (peak_ready_i),
    .busy_o        (busy_o),
    .frame_count_o (frame_count_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      bin;
    logic [2*DW-1:0] mag;
  } exp_t;

  exp_t                sb[$];
  logic signed [DW-1:0] fre [N];
  logic signed [DW-1:0] fim [N];
  int   total = 0;
  int   bad   = 0;
  int   exp_count = 0;
  logic [7:0]      last_bin = '0;
  logic [2*DW-1:0] last_mag = '0;

  task automatic fill_frame(input int re, input int im);
    for (int i = 0; i < N; i++) begin
      fre[i] = DW'(re);
      fim[i] = DW'(im);
    end
  endtask

  // Drives nbins bins (optionally with random gaps); a full frame also pushes the expected report.
  task automatic send_frame(input int nbins, input int max_gap, input bit start);
    bit      hs_ok = 1'b1;
    longint  best = 0;
    int      bb = MB;
    exp_t    e;
    if (start) begin
      frame_ready_i = 1'b1;
      @(posedge clk); #1;
      frame_ready_i = 1'b0;
    end
    for (int i = 0; i < nbins; i++) begin
      if (max_gap > 0) begin
        bin_valid_i = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk); #1;
        end
      end
      bin_data_i  = {fim[i], fre[i]};
      bin_valid_i = 1'b1;
      if (bin_ready_o !== 1'b1) hs_ok = 1'b0;
      @(posedge clk); #1;
    end
    bin_valid_i = 1'b0;
    total++;
    if (!hs_ok) begin
      bad++;
      $display("FAIL bin_ready_during_frame: got not-ready on a handshake, required ready");
    end
    if (nbins == N) begin
      for (int i = MB; i < SB; i++) begin
        longint m;
        m = longint'(fre[i]) * longint'(fre[i]) + longint'(fim[i]) * longint'(fim[i]);
        if (m > best) begin
          best = m;
          bb   = i;
        end
      end
      e.bin = 8'(bb);
      e.mag = (2*DW)'(best);
      sb.push_back(e);
      total++;
      if (peak_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL report_latency: peak_valid_o=%b required 1", peak_valid_o);
      end
    end
  endtask

  // Waits for the report, optionally holds it for `hold` cycles, then handshakes and checks.
  task automatic collect(input int hold);
    exp_t            e;
    int              w = 0;
    bit              stable = 1'b1;
    logic [7:0]      sbin;
    logic [2*DW-1:0] smag;
    logic [15:0]     scnt;
    while (peak_valid_o !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    e = sb.pop_front();
    total++;
    if (peak_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL report_timeout: peak_valid_o=%b after %0d cycles, required 1", peak_valid_o, w);
      return;
    end
    sbin = peak_bin_o;
    smag = peak_mag_o;
    scnt = frame_count_o;
    for (int c = 0; c < hold; c++) begin
      if (peak_valid_o !== 1'b1 || bin_ready_o !== 1'b0 || peak_bin_o !== sbin ||
          peak_mag_o !== smag || frame_count_o !== scnt) stable = 1'b0;
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      total++;
      if (!stable) begin
        bad++;
        $display("FAIL report_hold: outputs changed or bin_ready_o high while stalled, required stable");
      end
    end
    total++;
    if (peak_bin_o !== e.bin) begin
      bad++;
      $display("FAIL peak_bin: got %0d required %0d", peak_bin_o, e.bin);
    end
    total++;
    if (peak_mag_o !== e.mag) begin
      bad++;
      $display("FAIL peak_mag: got %0d required %0d", peak_mag_o, e.mag);
    end
    last_bin = e.bin;
    last_mag = e.mag;
    peak_ready_i = 1'b1;
    @(posedge clk); #1;
    peak_ready_i = 1'b0;
    exp_count++;
    total++;
    if (frame_count_o !== 16'(exp_count)) begin
      bad++;
      $display("FAIL frame_count: got %0d required %0d", frame_count_o, exp_count);
    end
    total++;
    if (peak_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL after_report: valid=%b busy=%b required 0 0", peak_valid_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    total++;
    if (bin_ready_o !== 1'b0 || peak_valid_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: ready=%b valid=%b busy=%b ovr=%b required 0", bin_ready_o,
               peak_valid_o, busy_o, overrun_o);
    end
    total++;
    if (frame_count_o !== 16'd0 || peak_bin_o !== 8'd0 || peak_mag_o !== '0) begin
      bad++;
      $display("FAIL reset_values: cnt=%0d bin=%0d mag=%0d required 0", frame_count_o, peak_bin_o,
               peak_mag_o);
    end
  endtask

  task automatic test_single_tone();
    fill_frame(1, 1);
    fre[37] = 18'sd1000;
    fim[37] = 18'sd0;
    send_frame(N, 0, 1'b1);
    collect(0);
  endtask

  task automatic test_dc_exclusion();
    fill_frame(0, 0);
    fre[0]   = 18'sd30000;
    fre[200] = 18'sd30000;
    fim[200] = 18'sd30000;
    fre[5]   = 18'sd10;
    send_frame(N, 0, 1'b1);
    collect(0);
  endtask

  task automatic test_tie_extreme();
    fill_frame(0, 0);
    fre[10] = -18'sd131072;
    fim[10] = -18'sd131072;
    fre[20] = -18'sd131072;
    fim[20] = -18'sd131072;
    send_frame(N, 0, 1'b1);
    collect(0);
  endtask

  task automatic test_all_zero();
    fill_frame(0, 0);
    send_frame(N, 0, 1'b1);
    collect(0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) begin
      fre[i] = DW'($urandom());
      fim[i] = DW'($urandom());
    end
    send_frame(N, 3, 1'b1);
    collect(50);
  endtask

  task automatic test_back_to_back();
    fill_frame(0, 0);
    fre[3] = 18'sd7;
    send_frame(N, 0, 1'b1);
    frame_ready_i = 1'b1;
    collect(0);
    @(posedge clk); #1;
    frame_ready_i = 1'b0;
    total++;
    if (busy_o !== 1'b1 || bin_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back_start: busy=%b ready=%b required 1 1", busy_o, bin_ready_o);
    end
    total++;
    if (peak_bin_o !== last_bin || peak_mag_o !== last_mag) begin
      bad++;
      $display("FAIL hold_last_report: bin=%0d mag=%0d required %0d %0d", peak_bin_o, peak_mag_o,
               last_bin, last_mag);
    end
    fill_frame(2, 0);
    fim[100] = -18'sd40;
    send_frame(N, 0, 1'b0);
    collect(0);
  endtask

  task automatic test_overrun();
    bin_valid_i = 1'b1;
    bin_data_i  = '1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bin_valid_i = 1'b0;
    total++;
    if (overrun_o !== 1'b1 || bin_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL overrun: ovr=%b ready=%b busy=%b required 1 0 0", overrun_o, bin_ready_o,
               busy_o);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (overrun_o !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: ovr=%b required 1", overrun_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    fill_frame(3, 3);
    send_frame(100, 0, 1'b1);
    total++;
    if (busy_o !== 1'b1 || peak_bin_o !== last_bin) begin
      bad++;
      $display("FAIL mid_frame_state: busy=%b bin=%0d required 1 %0d", busy_o, peak_bin_o, last_bin);
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_count = 0;
    total++;
    if (busy_o !== 1'b0 || frame_count_o !== 16'd0 || peak_valid_o !== 1'b0 || overrun_o !== 1'b0)
    begin
      bad++;
      $display("FAIL mid_frame_reset: busy=%b cnt=%0d valid=%b ovr=%b required 0", busy_o,
               frame_count_o, peak_valid_o, overrun_o);
    end
    fill_frame(1, -1);
    fre[77] = -18'sd500;
    fim[77] = 18'sd300;
    send_frame(N, 0, 1'b1);
    collect(0);
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_dc_exclusion();
    test_tie_extreme();
    test_all_zero();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
